// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store front-end with sub-word read-modify-write
// Converts byte/half/word requests into aligned word accesses.
module mem_access_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_load,
   input  logic              req_store,
   input  logic [1:0]        size,
   input  logic              uns,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] store_data,
   input  logic [DATA_W-1:0] mem_rd,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wd,
   output logic [DATA_W-1:0] load_data,
   output logic              stall,
   output logic              misalign
);
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_MERGE = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [DATA_W-1:0] merge_q, merge_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic              is_word, is_half, any_req, bad_align;
   logic              ok_load, ok_store, sub_store;
   logic [ADDR_W-1:0] word_addr;
   logic [DATA_W-1:0] lane_bytes, lane_halves, ext_load, merged;

   // size=11 decodes as word, alignment check included
   assign is_word   = size[1];
   assign is_half   = (size == 2'b01);
   assign any_req   = req_load | req_store;
   assign bad_align = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
   assign ok_store  = req_store & ~bad_align;
   assign ok_load   = req_load & ~req_store & ~bad_align;
   assign sub_store = ok_store & ~is_word;
   assign word_addr = {addr[ADDR_W-1:2], 2'b00};

   assign lane_bytes  = mem_rd >> {addr[1:0], 3'b000};
   assign lane_halves = mem_rd >> {addr[1], 4'b0000};

   always_comb begin
      ext_load = mem_rd;
      if (!is_word) begin
         if (is_half) begin
            ext_load = {{16{~uns & lane_halves[15]}}, lane_halves[15:0]};
         end else begin
            ext_load = {{24{~uns & lane_bytes[7]}}, lane_bytes[7:0]};
         end
      end
   end

   always_comb begin
      merged = mem_rd;
      if (is_half) begin
         merged[{addr[1], 4'b0000} +: 16] = store_data[15:0];
      end else begin
         merged[{addr[1:0], 3'b000} +: 8] = store_data[7:0];
      end
   end

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wd    = '0;
      load_data = '0;
      stall     = 1'b0;
      misalign  = 1'b0;
      state_d   = state_q;
      merge_d   = merge_q;
      addr_d    = addr_q;
      if (state_q == S_MERGE) begin
         mem_write = 1'b1;
         mem_addr  = addr_q;
         mem_wd    = merge_q;
         state_d   = S_IDLE;
      end else begin
         mem_addr = word_addr;
         misalign = any_req & bad_align;
         if (ok_load) begin
            mem_read  = 1'b1;
            load_data = ext_load;
         end else if (ok_store & is_word) begin
            mem_write = 1'b1;
            mem_wd    = store_data;
         end else if (sub_store) begin
            mem_read = 1'b1;
            stall    = 1'b1;
            state_d  = S_MERGE;
            merge_d  = merged;
            addr_d   = word_addr;
         end
      end
      // Outputs go quiet the instant reset asserts so a MERGE write is aborted cleanly
      if (!rst_n) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
         mem_addr  = '0;
         mem_wd    = '0;
         load_data = '0;
         stall     = 1'b0;
         misalign  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         merge_q <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         merge_q <= merge_d;
         addr_q  <= addr_d;
      end
   end
endmodule
